// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder and the core's control decoder:
// mnemonic set, opcode/funct map, instruction formats and encoder FSM states.
package isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD     = 5'd0,
        MN_SUB     = 5'd1,
        MN_ADDI    = 5'd2,
        MN_ADD_FP  = 5'd3,
        MN_MUL_FP  = 5'd4,
        MN_VADD_FP = 5'd5,
        MN_VMUL_FP = 5'd6,
        MN_VSUM_FP = 5'd7,
        MN_SW      = 5'd8,
        MN_LW      = 5'd9,
        MN_SW_FP   = 5'd10,
        MN_LW_FP   = 5'd11,
        MN_VST     = 5'd12,
        MN_VLD     = 5'd13,
        MN_BEQ     = 5'd14,
        MN_BLT     = 5'd15,
        MN_J       = 5'd16,
        MN_VSET_FP = 5'd17,
        MN_START   = 5'd18,
        MN_CLOSE   = 5'd19
    } mnem_t;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_ALU     = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b010000;
    localparam logic [5:0] OP_FP      = 6'b000100;
    localparam logic [5:0] OP_VFP     = 6'b001100;
    localparam logic [5:0] OP_SW      = 6'b010001;
    localparam logic [5:0] OP_LW      = 6'b010010;
    localparam logic [5:0] OP_SW_FP   = 6'b010101;
    localparam logic [5:0] OP_LW_FP   = 6'b010110;
    localparam logic [5:0] OP_VST     = 6'b011101;
    localparam logic [5:0] OP_VLD     = 6'b011110;
    localparam logic [5:0] OP_BEQ     = 6'b100000;
    localparam logic [5:0] OP_BLT     = 6'b100001;
    localparam logic [5:0] OP_J       = 6'b100010;
    localparam logic [5:0] OP_VSET_FP = 6'b111111;
    localparam logic [5:0] OP_START   = 6'b110010;
    localparam logic [5:0] OP_CLOSE   = 6'b110001;

    // Functs (R-type only)
    localparam logic [5:0] FN_ADD     = 6'b000000;
    localparam logic [5:0] FN_SUB     = 6'b000001;
    localparam logic [5:0] FN_ADD_FP  = 6'b000000;
    localparam logic [5:0] FN_MUL_FP  = 6'b000001;
    localparam logic [5:0] FN_VADD_FP = 6'b000000;
    localparam logic [5:0] FN_VMUL_FP = 6'b000001;
    localparam logic [5:0] FN_VSUM_FP = 6'b000010;

    function automatic fmt_t fmt_of(input mnem_t m);
        unique case (m)
            MN_ADD, MN_SUB, MN_ADD_FP, MN_MUL_FP,
            MN_VADD_FP, MN_VMUL_FP, MN_VSUM_FP: return FMT_R;
            MN_J:                               return FMT_J;
            default:                            return FMT_I;
        endcase
    endfunction

endpackage

// File: rtl/isa_word_pack.sv
// Combinational packer: mnemonic plus register/immediate fields -> 32-bit
// instruction word, with a legal flag for mnemonics outside the opcode map.
module isa_word_pack
    import isa_pkg::*;
(
    input  mnem_t       i_mnem,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_bare;
    fmt_t       w_fmt;

    // NOTE: every signal driven in always_comb gets a default first; a missing
    // branch would otherwise hold the old value and infer a latch.
    always_comb begin
        w_op    = OP_ALU;
        w_funct = 6'b000000;
        w_bare  = 1'b0;
        o_legal = 1'b1;
        unique case (i_mnem)
            MN_ADD:     begin w_op = OP_ALU;  w_funct = FN_ADD;     end
            MN_SUB:     begin w_op = OP_ALU;  w_funct = FN_SUB;     end
            MN_ADDI:    w_op = OP_ADDI;
            MN_ADD_FP:  begin w_op = OP_FP;   w_funct = FN_ADD_FP;  end
            MN_MUL_FP:  begin w_op = OP_FP;   w_funct = FN_MUL_FP;  end
            MN_VADD_FP: begin w_op = OP_VFP;  w_funct = FN_VADD_FP; end
            MN_VMUL_FP: begin w_op = OP_VFP;  w_funct = FN_VMUL_FP; end
            MN_VSUM_FP: begin w_op = OP_VFP;  w_funct = FN_VSUM_FP; end
            MN_SW:      w_op = OP_SW;
            MN_LW:      w_op = OP_LW;
            MN_SW_FP:   w_op = OP_SW_FP;
            MN_LW_FP:   w_op = OP_LW_FP;
            MN_VST:     w_op = OP_VST;
            MN_VLD:     w_op = OP_VLD;
            MN_BEQ:     w_op = OP_BEQ;
            MN_BLT:     w_op = OP_BLT;
            MN_J:       w_op = OP_J;
            MN_VSET_FP: w_op = OP_VSET_FP;
            MN_START:   begin w_op = OP_START; w_bare = 1'b1; end
            MN_CLOSE:   begin w_op = OP_CLOSE; w_bare = 1'b1; end
            default:    o_legal = 1'b0;
        endcase
    end

    assign w_fmt = fmt_of(i_mnem);

    // Program delimiters carry only their opcode.
    always_comb begin
        o_word = 32'd0;
        if (w_bare) begin
            o_word = {w_op, 26'd0};
        end else begin
            unique case (w_fmt)
                FMT_R:   o_word = {w_op, i_rd, i_rs, i_rt, 5'd0, w_funct};
                FMT_J:   o_word = {w_op, i_imm};
                default: o_word = {w_op, i_rd, i_rs, i_imm[15:0]};
            endcase
        end
    end

endmodule

// File: rtl/isa_encoder.sv
// Instruction encoder / instruction-memory loader: accepts symbolic instructions,
// writes packed words at incrementing addresses and holds the core until CLOSE.
module isa_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  mnem_t             in_mnem,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_hold;
    logic                r_done;
    logic                r_error;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_accept;
    logic                w_open;

    isa_word_pack u_pack (
        .i_mnem  (in_mnem),
        .i_rd    (in_rd),
        .i_rs    (in_rs),
        .i_rt    (in_rt),
        .i_imm   (in_imm),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign in_ready = w_open && !clear;
    assign w_accept = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_legal && in_mnem == MN_START) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + 1'b1;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (!w_legal) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + 1'b1;
                            if (in_mnem == MN_CLOSE) begin
                                r_state <= ST_DONE;
                                r_hold  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (r_count == LAST_SLOT) begin
                                // Last slot used by a non-CLOSE word: CLOSE can never fit.
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_isa_encoder.sv
// Directed bench for isa_encoder: encodings, FSM paths, clear/reset behaviour,
// full condition on a tiny instance and irregular in_valid pacing.
module tb_isa_encoder;
    import isa_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, in_valid, in_ready;
    mnem_t       in_mnem;
    logic [4:0]  in_rd, in_rs, in_rt;
    logic [25:0] in_imm;
    logic        imem_we, cpu_hold, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] word_count;

    logic        s_clear, s_valid, s_ready;
    mnem_t       s_mnem;
    logic [4:0]  s_rd, s_rs, s_rt;
    logic [25:0] s_imm;
    logic        s_we, s_hold, s_done, s_error;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    isa_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    isa_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_valid), .in_ready(s_ready), .in_mnem(s_mnem),
        .in_rd(s_rd), .in_rs(s_rs), .in_rt(s_rt), .in_imm(s_imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_hold(s_hold), .done(s_done), .error(s_error), .word_count(s_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mnem_t m, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [25:0] imm);
        in_valid = 1'b1;
        in_mnem  = m;
        in_rd    = rd;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
    endtask

    task automatic s_drive(input mnem_t m, input logic [4:0] rd);
        s_valid = 1'b1;
        s_mnem  = m;
        s_rd    = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   k;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mnem = MN_ADD;
        in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_mnem = MN_ADD;
        s_rd = '0; s_rs = '0; s_rt = '0; s_imm = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_done_err", {done, error}, 0);
        check("rst_count", word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // START, ADDI, CLOSE back-to-back
        drive(MN_START, 0, 0, 0, 0);
        tick();
        check("start_we", imem_we, 1);
        check("start_addr", imem_addr, 0);
        check("start_word", imem_wdata, 32'hC800_0000);
        check("start_hold", cpu_hold, 1);
        drive(MN_ADDI, 1, 0, 0, 5);
        tick();
        check("addi_we", imem_we, 1);
        check("addi_addr", imem_addr, 1);
        check("addi_word", imem_wdata, 32'h4020_0005);
        drive(MN_CLOSE, 0, 0, 0, 0);
        tick();
        check("close_we", imem_we, 1);
        check("close_addr", imem_addr, 2);
        check("close_word", imem_wdata, 32'hC400_0000);
        check("close_done", done, 1);
        check("close_hold", cpu_hold, 0);
        check("close_count", word_count, 3);
        check("done_ready", in_ready, 0);
        drive(MN_START, 0, 0, 0, 0);
        tick();
        check("done_no_write", imem_we, 0);
        check("done_stays", done, 1);

        // clear beats a simultaneous handshake
        clear = 1'b1;
        tick();
        check("clear_count", word_count, 0);
        check("clear_done", done, 0);
        check("clear_hold", cpu_hold, 1);
        check("clear_idle_ready", in_ready, 0);
        tick();
        check("clear_prio_we", imem_we, 0);
        check("clear_prio_count", word_count, 0);
        clear = 1'b0;
        #1;
        check("idle_ready", in_ready, 1);

        // Encodings in LOAD, then illegal mnemonic
        drive(MN_START, 0, 0, 0, 0);
        tick();
        drive(MN_SUB, 3, 1, 2, 0);
        tick();
        check("sub_addr", imem_addr, 1);
        check("sub_word", imem_wdata, 32'h0061_1001);
        drive(MN_VSUM_FP, 4, 5, 6, 0);
        tick();
        check("vsum_addr", imem_addr, 2);
        check("vsum_word", imem_wdata, 32'h3085_3002);
        drive(MN_J, 0, 0, 0, 26'h10);
        tick();
        check("j_addr", imem_addr, 3);
        check("j_word", imem_wdata, 32'h8800_0010);
        drive(mnem_t'(5'd25), 1, 1, 1, 1);
        tick();
        check("illegal_we", imem_we, 0);
        check("illegal_err", error, 1);
        check("illegal_count", word_count, 4);
        check("illegal_ready", in_ready, 0);
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // LW first in IDLE
        drive(MN_LW, 1, 2, 0, 8);
        tick();
        check("lw_idle_we", imem_we, 0);
        check("lw_idle_err", error, 1);
        check("lw_idle_ready", in_ready, 0);
        check("lw_idle_hold", cpu_hold, 1);
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("lw_clear_count", word_count, 0);
        check("lw_clear_err", error, 0);
        check("lw_clear_ready", in_ready, 1);

        // Asynchronous reset mid-stream, in_valid held high
        drive(MN_START, 0, 0, 0, 0);
        tick();
        drive(MN_ADD, 1, 2, 3, 0);
        tick();
        check("pre_rst_we", imem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", imem_we, 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_wdata", imem_wdata, 0);
        check("midrst_count", word_count, 0);
        check("midrst_hold", cpu_hold, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(MN_START, 0, 0, 0, 0);
        tick();
        check("post_rst_we", imem_we, 1);
        check("post_rst_addr", imem_addr, 0);
        check("post_rst_word", imem_wdata, 32'hC800_0000);

        // Irregular in_valid: 12 ADDIs then CLOSE, each written once, in order
        k = 0;
        for (int cyc = 0; cyc < 300 && k <= 12; cyc++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_rd = '0; in_rs = '0; in_rt = '0;
            in_mnem = (k == 12) ? MN_CLOSE : MN_ADDI;
            in_imm  = 26'h100 + 26'(k);
            acc = in_valid;
            #1;
            check("rand_ready", in_ready, 1);
            tick();
            if (acc) begin
                check("rand_we", imem_we, 1);
                check("rand_addr", imem_addr, 64'(1 + k));
                check("rand_word", imem_wdata, (k == 12) ? 32'hC400_0000 : 32'h4000_0100 + 32'(k));
                k++;
            end else begin
                check("rand_idle_we", imem_we, 0);
            end
        end
        check("rand_all_sent", k, 13);
        check("rand_done", done, 1);
        check("rand_hold", cpu_hold, 0);
        check("rand_count", word_count, 14);
        drive(MN_ADDI, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rand_done_hold_we", imem_we, 0);
            check("rand_done_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // Full condition on ADDR_W=2: START + 3 ADDs fills all four slots
        s_drive(MN_START, 0);
        tick();
        check("full_start_addr", s_addr, 0);
        s_drive(MN_ADD, 1);
        tick();
        tick();
        check("full_third_addr", s_addr, 2);
        check("full_third_err", s_error, 0);
        tick();
        check("full_last_we", s_we, 1);
        check("full_last_addr", s_addr, 3);
        check("full_last_word", s_wdata, 32'h0020_0000);
        check("full_err", s_error, 1);
        check("full_count", s_count, 4);
        check("full_ready", s_ready, 0);
        tick();
        check("full_no_wrap_we", s_we, 0);
        s_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/isa_encoder.md
# isa_encoder

Instruction encoder and instruction-memory writer for the vector/FP processor. It accepts symbolic instructions (mnemonic plus register and immediate fields) over a valid/ready stream and packs each into a 32-bit instruction word. Each word is written into instruction memory at an incrementing address. While a program is loading, the core is held off, and the hold is released once CLOSE has been written. This block is the producing end of the opcode/funct encoding that the core's control decoder consumes.

## Interface
- `ADDR_W`, default 10: instruction memory address width, so the memory depth is 2^ADDR_W words.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous soft clear. Returns the block to IDLE with all counters zeroed.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the block can accept an instruction this cycle.
- `in_mnem` in 5: mnemonic, typed as `isa_pkg::mnem_t`.
- `in_rd`, `in_rs`, `in_rt` in 5 each: register fields.
- `in_imm` in 26: immediate. The low 16 bits are used for I-type; all 26 bits are used for J-type.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: encoded instruction word.
- `cpu_hold` out 1: keeps the core in reset or stall while a program loads.
- `done` out 1: the program is complete.
- `error` out 1: sticky error flag.
- `word_count` out ADDR_W+1: number of words written so far.

## Operation
- **Encoding formats:**
  - R-type: op[31:26], rd[25:21], rs[20:16], rt[15:11], zero[10:6], funct[5:0].
  - I-type: op, rd, rs, imm[15:0].
  - J-type: op, imm[25:0].
- **Opcode map:**
  - ADD (funct 000000) and SUB (funct 000001) use op 000000.
  - ADDI uses op 010000.
  - ADD_FP (funct 000000) and MUL_FP (funct 000001) use op 000100.
  - VADD_FP, VMUL_FP and VSUM_FP use op 001100 with funct 000000, 000001 and 000010 respectively.
  - SW 010001, LW 010010, SW_FP 010101, LW_FP 010110.
  - VST 011101, VLD 011110.
  - BEQ 100000, BLT 100001, J 100010.
  - VSET_FP 111111.
  - START 110010, CLOSE 110001.
- **Format per mnemonic:**
  - R-type: ADD, SUB, ADD_FP, MUL_FP, VADD_FP, VMUL_FP, VSUM_FP.
  - J-type: J.
  - I-type: everything else.
  - START and CLOSE are encoded with all non-opcode fields zero.
- **FSM states:** IDLE, LOAD, DONE, ERROR.
  - IDLE:
    - Accepting START writes it at address 0 and moves to LOAD.
    - Accepting any other legal mnemonic moves to ERROR, and nothing is written.
  - LOAD:
    - Every accepted instruction is written at the next address.
    - Accepting CLOSE writes it and moves to DONE.
  - DONE: `in_ready`=0, `cpu_hold`=0, `done`=1. Leaves only on `clear` or reset.
  - ERROR: `in_ready`=0, `cpu_hold`=1, `error`=1. Leaves only on `clear` or reset.
- **Illegal mnemonic:** any enum value outside the map moves the block to ERROR and nothing is written.
- **Full condition:** a non-CLOSE instruction accepted when `word_count` = 2^ADDR_W−1 (i.e. written to the last slot) is still written. The block then moves to ERROR, because there is no room left for CLOSE.
- **Address counter:** increments by 1 per write. It never wraps: the ERROR transition occurs before wrap-around could happen.
- **Clear priority:** `clear` takes priority over any simultaneous handshake. The instruction offered in that cycle is not accepted.
- **`in_ready`:** equals 1 in IDLE and LOAD when `clear`=0, and 0 otherwise.

## Timing
- **Accept:** an instruction is accepted on a rising edge where `in_valid` and `in_ready` are both 1.
- **Write latency:** `imem_we`, `imem_addr` and `imem_wdata` are registered and appear in the cycle after acceptance. `imem_we` is high for exactly one cycle per accepted word.
- **Throughput:** one instruction per cycle, back-to-back.
- **Status outputs:** the `word_count` and state updates land on the same edge as the registered write.
- **Reset values:**
  - `in_ready`=1 and `cpu_hold`=1 (state IDLE).
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `done`=0, `error`=0, `word_count`=0.
- **Reset mid-load:** reset asynchronously aborts any pending write. `imem_we` drops immediately. Memory contents are not scrubbed.
- **`cpu_hold` release:** deasserts in the cycle the CLOSE write is presented. It is never released before that write.

## Structure
- **`isa_pkg`** holds:
  - the `mnem_t` enum;
  - `localparam`s for the opcodes and functs listed above;
  - the `fmt_t` enum {R, I, J};
  - a `state_t` enum.

  The control decoder imports the same constants.
- **`isa_word_pack`** is a combinational sub-module. It maps mnemonic and fields to {word, legal}.
- **Top level** contains the FSM, the address counter and the output registers.

## Test plan
- START, ADDI(rd=1, rs=0, imm=5), CLOSE sent back-to-back produces:
  - words 0xC8000000, 0x40200005, 0xC4000000 at addresses 0, 1, 2 on consecutive cycles;
  - `done`=1 and `cpu_hold`=0 after the third write.
- In LOAD, SUB(rd=3, rs=1, rt=2) produces 0x00611001. VSUM_FP(4, 5, 6) produces 0x30853002. J(imm=0x10) produces 0x88000010.
- LW issued first while in IDLE: no `imem_we`, `error`=1, `in_ready`=0. A subsequent `clear` returns to IDLE with `word_count`=0.
- With ADDR_W=2: START plus three ADDs causes the fourth word to be written at address 3, then ERROR with `word_count`=4.
- Reset is asserted mid-stream with `in_valid` held high: outputs take their reset values immediately, and the next START is written at address 0.
- `in_valid` is toggled randomly, including holds while `in_ready`=0: each accepted instruction is written exactly once and in order.
